// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit 7-segment display.
// Each digit slot opens with a blanking interval so the segment mux can settle while no digit
// is lit. Disabled digits keep their slot and run dark, so the frame period never changes.
module seg_scan_ctrl #(
  parameter int unsigned SLOT_CYC  = 50000,
  parameter int unsigned BLANK_CYC = 500,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] digit_en,
  output logic [3:0] sel,
  output logic [1:0] digit_idx,
  output logic       slot_start,
  output logic       frame_start
);

  typedef enum logic [1:0] {StOff, StBlank, StOn} state_e;

  localparam logic [CNT_W-1:0] SlotLast  = CNT_W'(SLOT_CYC - 1);
  // Only compared while in StBlank, which is unreachable when BLANK_CYC is 0.
  localparam logic [CNT_W-1:0] BlankLast = (BLANK_CYC == 0) ? '0 : CNT_W'(BLANK_CYC - 1);
  localparam state_e           SlotFirst = (BLANK_CYC == 0) ? StOn : StBlank;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       sel_q, sel_d;
  logic             slot_start_q, slot_start_d;
  logic             frame_start_q, frame_start_d;

  // Next-state logic; outputs are computed from the next state so they can be registered.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    slot_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (!en) begin
      // Dropping en abandons the frame at once.
      state_d = StOff;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == StOff) begin
      state_d       = SlotFirst;
      cnt_d         = '0;
      idx_d         = '0;
      slot_start_d  = 1'b1;
      frame_start_d = 1'b1;
    end else if (cnt_q == SlotLast) begin
      state_d       = SlotFirst;
      cnt_d         = '0;
      idx_d         = idx_q + 2'd1;
      slot_start_d  = 1'b1;
      frame_start_d = (idx_d == 2'd0);
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (state_q == StBlank && cnt_q == BlankLast) begin
        state_d = StOn;
      end
    end

    // digit_en is sampled every cycle, so a mask change lands on sel mid-slot.
    sel_d = 4'b1111;
    if (state_d == StOn && digit_en[idx_d]) begin
      sel_d = ~(4'b0001 << idx_d);
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StOff;
      cnt_q         <= '0;
      idx_q         <= '0;
      sel_q         <= 4'b1111;
      slot_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      sel_q         <= sel_d;
      slot_start_q  <= slot_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign sel         = sel_q;
  assign digit_idx   = idx_q;
  assign slot_start  = slot_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: one instance with blanking (8/2), one without (4/0).
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a, en_b;
  logic [3:0] den_a, den_b;
  logic [3:0] sel_a, sel_b;
  logic [1:0] idx_a, idx_b;
  logic       ss_a, ss_b, fs_a, fs_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SLOT_CYC(8), .BLANK_CYC(2), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .digit_en(den_a),
    .sel(sel_a), .digit_idx(idx_a), .slot_start(ss_a), .frame_start(fs_a)
  );

  seg_scan_ctrl #(.SLOT_CYC(4), .BLANK_CYC(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .digit_en(den_b),
    .sel(sel_b), .digit_idx(idx_b), .slot_start(ss_b), .frame_start(fs_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves dut_a one cycle into a fresh scan (k=0: first cycle of slot 0).
  task automatic start_a(input logic [3:0] de);
    en_a  = 1'b0;
    den_a = de;
    step();
    en_a = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en_a  = 1'b0;
    en_b  = 1'b0;
    den_a = 4'hF;
    den_b = 4'hF;
    #12;
    total++;
    if ({sel_a, idx_a, ss_a, fs_a} !== {4'hF, 2'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_a got sel=%b idx=%0d ss=%b fs=%b want 1111/0/0/0",
               sel_a, idx_a, ss_a, fs_a);
    end
    total++;
    if ({sel_b, idx_b, ss_b, fs_b} !== {4'hF, 2'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_b got sel=%b idx=%0d ss=%b fs=%b want 1111/0/0/0",
               sel_b, idx_b, ss_b, fs_b);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({sel_a, idx_a, ss_a, fs_a} !== {4'hF, 2'd0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL idle_off cyc=%0d got sel=%b idx=%0d ss=%b fs=%b want 1111/0/0/0",
                 i, sel_a, idx_a, ss_a, fs_a);
      end
    end
  endtask

  // Two full frames with a digit mask; k counts cycles since the scan start.
  task automatic test_scan(input logic [3:0] de, input string name);
    logic [3:0] e_sel;
    logic [1:0] e_idx;
    logic       e_ss, e_fs;
    int         s, c;
    start_a(de);
    for (int k = 0; k < 64; k++) begin
      s     = (k / 8) % 4;
      c     = k % 8;
      e_idx = 2'(s);
      e_sel = (c < 2 || !de[s]) ? 4'hF : ~(4'b0001 << s);
      e_ss  = (c == 0);
      e_fs  = (k % 32 == 0);
      total++;
      if ({sel_a, idx_a, ss_a, fs_a} !== {e_sel, e_idx, e_ss, e_fs}) begin
        bad++;
        $display("FAIL %s k=%0d got sel=%b idx=%0d ss=%b fs=%b want sel=%b idx=%0d ss=%b fs=%b",
                 name, k, sel_a, idx_a, ss_a, fs_a, e_sel, e_idx, e_ss, e_fs);
      end
      step();
    end
  endtask

  task automatic test_noblank();
    logic [3:0] e_sel;
    int         s;
    den_b = 4'hF;
    en_b  = 1'b1;
    step();
    for (int k = 0; k < 40; k++) begin
      s     = (k / 4) % 4;
      e_sel = ~(4'b0001 << s);
      total++;
      if ({sel_b, idx_b, ss_b, fs_b} !== {e_sel, 2'(s), k % 4 == 0, k % 16 == 0}) begin
        bad++;
        $display("FAIL noblank k=%0d got sel=%b idx=%0d ss=%b fs=%b want sel=%b idx=%0d ss=%b fs=%b",
                 k, sel_b, idx_b, ss_b, fs_b, e_sel, s, k % 4 == 0, k % 16 == 0);
      end
      step();
    end
  endtask

  // Slot 0 of a freshly started scan (digit_en=1111), checked from k=0 to k=9.
  task automatic check_restart(input string name);
    logic [3:0] e_sel;
    int         s, c;
    for (int k = 0; k < 10; k++) begin
      s     = k / 8;
      c     = k % 8;
      e_sel = (c < 2) ? 4'hF : ~(4'b0001 << s);
      total++;
      if ({sel_a, idx_a, ss_a, fs_a} !== {e_sel, 2'(s), c == 0, k == 0}) begin
        bad++;
        $display("FAIL %s k=%0d got sel=%b idx=%0d ss=%b fs=%b want sel=%b idx=%0d ss=%b fs=%b",
                 name, k, sel_a, idx_a, ss_a, fs_a, e_sel, s, c == 0, k == 0);
      end
      step();
    end
  endtask

  task automatic test_en_drop();
    start_a(4'hF);
    for (int k = 0; k < 21; k++) step();  // slot 2, cnt 5
    en_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({sel_a, idx_a, ss_a, fs_a} !== {4'hF, 2'd0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL en_drop cyc=%0d got sel=%b idx=%0d ss=%b fs=%b want 1111/0/0/0",
                 i, sel_a, idx_a, ss_a, fs_a);
      end
    end
    en_a = 1'b1;
    step();
    check_restart("en_restart");
  endtask

  task automatic test_async_reset();
    start_a(4'hF);
    for (int k = 0; k < 28; k++) step();  // slot 3, cnt 4
    total++;
    if (sel_a !== 4'b0111) begin
      bad++;
      $display("FAIL pre_reset got sel=%b want 0111", sel_a);
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({sel_a, idx_a, ss_a, fs_a} !== {4'hF, 2'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset got sel=%b idx=%0d ss=%b fs=%b want 1111/0/0/0",
               sel_a, idx_a, ss_a, fs_a);
    end
    #2;
    rst_n = 1'b1;
    step();
    check_restart("post_reset");
  endtask

  task automatic test_mask_change();
    logic [3:0] e_sel;
    start_a(4'hF);
    for (int k = 0; k < 24; k++) begin
      if (k == 12) den_a = 4'b1101;  // sampled at the edge into k=13
      if (k < 8) e_sel = (k < 2) ? 4'hF : 4'b1110;
      else if (k < 16) e_sel = (k >= 10 && k <= 12) ? 4'b1101 : 4'hF;
      else e_sel = (k < 18) ? 4'hF : 4'b1011;
      total++;
      if (sel_a !== e_sel) begin
        bad++;
        $display("FAIL mask_change k=%0d got sel=%b want %b", k, sel_a, e_sel);
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_scan(4'hF, "scan_all");
    test_scan(4'b1010, "scan_mask");
    test_noblank();
    test_en_drop();
    test_async_reset();
    test_mask_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
